// File: rtl/bullet_manager.sv
// Bullet slot table: spawn handshake, once-per-frame move sweep, kill port,
// and registered per-pixel sprite lookup outputs for the bullet renderer.
module bullet_manager #(
    parameter int unsigned N_SLOTS  = 20,
    parameter int unsigned B_SIZE   = 36,
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned V_ACTIVE = 480
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    frame_tick,
    input  logic [9:0]              hc,
    input  logic [9:0]              vc,
    input  logic                    fire_req,
    input  logic [9:0]              fire_x,
    input  logic [9:0]              fire_y,
    input  logic [3:0]              fire_angle,
    input  logic [3:0]              fire_type,
    output logic                    fire_ack,
    output logic                    fire_drop,
    input  logic                    kill_valid,
    input  logic [4:0]              kill_slot,
    output logic [N_SLOTS-1:0]      bullet_active,
    output logic [N_SLOTS-1:0]      bullet_in_pixel,
    output logic [10*N_SLOTS-1:0]   bullet_hc,
    output logic [10*N_SLOTS-1:0]   bullet_vc,
    output logic [4*N_SLOTS-1:0]    bullet_angle,
    output logic [4*N_SLOTS-1:0]    bullet_type,
    output logic                    sweep_busy,
    output logic                    frame_overrun
);
    localparam logic [4:0]         LAST_IDX = 5'(N_SLOTS - 1);
    localparam logic signed [11:0] MAX_X    = 12'(H_ACTIVE - B_SIZE);
    localparam logic signed [11:0] MAX_Y    = 12'(V_ACTIVE - B_SIZE);
    localparam logic [10:0]        SPAN     = 11'(B_SIZE);

    typedef enum logic {IDLE, SWEEP} state_t;

    state_t             state, state_n;
    logic [4:0]         idx, idx_n;
    logic [9:0]         x_q   [N_SLOTS];
    logic [9:0]         y_q   [N_SLOTS];
    logic [3:0]         ang_q [N_SLOTS];
    logic [3:0]         typ_q [N_SLOTS];

    logic               free_found;
    logic [4:0]         free_idx;
    logic               kill_hit;
    logic [3:0]         ang_dy;
    logic signed [11:0] nx, ny;
    logic               leaving;

    // Per-angle step; the vertical step reuses the table rotated by a quarter turn.
    function automatic logic signed [11:0] vel(input logic [3:0] k);
        case (k)
            4'd0, 4'd1, 4'd15: vel = 12'sd4;
            4'd2, 4'd14:       vel = 12'sd3;
            4'd3, 4'd13:       vel = 12'sd2;
            4'd4, 4'd12:       vel = 12'sd0;
            4'd5, 4'd11:       vel = -12'sd2;
            4'd6, 4'd10:       vel = -12'sd3;
            default:           vel = -12'sd4;
        endcase
    endfunction

    always_comb begin
        state_n    = state;
        idx_n      = idx;
        fire_ack   = 1'b0;
        fire_drop  = 1'b0;
        free_found = 1'b0;
        free_idx   = '0;
        kill_hit   = kill_valid && (kill_slot < 5'(N_SLOTS));
        ang_dy     = ang_q[idx] + 4'd12;
        nx         = $signed({2'b00, x_q[idx]}) + vel(ang_q[idx]);
        ny         = $signed({2'b00, y_q[idx]}) + vel(ang_dy);
        leaving    = nx[11] || ny[11] || (nx > MAX_X) || (ny > MAX_Y);

        // Descending scan so the lowest free index is the one left standing.
        for (int i = int'(N_SLOTS) - 1; i >= 0; i--) begin
            if (!bullet_active[i]) begin
                free_found = 1'b1;
                free_idx   = 5'(i);
            end
        end

        case (state)
            IDLE: begin
                if (!RST) begin
                    if (frame_tick) begin
                        state_n = SWEEP;
                        idx_n   = '0;
                    end else if (fire_req) begin
                        fire_ack  = free_found;
                        fire_drop = !free_found;
                    end
                end
            end
            SWEEP: begin
                if (idx == LAST_IDX) begin
                    state_n = IDLE;
                    idx_n   = '0;
                end else begin
                    idx_n = idx + 5'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state           <= IDLE;
            idx             <= '0;
            sweep_busy      <= 1'b0;
            frame_overrun   <= 1'b0;
            bullet_active   <= '0;
            bullet_in_pixel <= '0;
            bullet_hc       <= '0;
            bullet_vc       <= '0;
            bullet_angle    <= '0;
            bullet_type     <= '0;
            for (int i = 0; i < int'(N_SLOTS); i++) begin
                x_q[i]   <= '0;
                y_q[i]   <= '0;
                ang_q[i] <= '0;
                typ_q[i] <= '0;
            end
        end else begin
            state      <= state_n;
            idx        <= idx_n;
            sweep_busy <= (state_n == SWEEP);
            if (frame_tick && (state == SWEEP))
                frame_overrun <= 1'b1;

            if (fire_ack) begin
                x_q[free_idx]           <= fire_x;
                y_q[free_idx]           <= fire_y;
                ang_q[free_idx]         <= fire_angle;
                typ_q[free_idx]         <= fire_type;
                bullet_active[free_idx] <= 1'b1;
            end

            // A kill aimed at the slot under the sweep suppresses its move entirely.
            if ((state == SWEEP) && bullet_active[idx] && !(kill_hit && (kill_slot == idx))) begin
                if (leaving) begin
                    bullet_active[idx] <= 1'b0;
                end else begin
                    x_q[idx] <= nx[9:0];
                    y_q[idx] <= ny[9:0];
                end
            end

            if (kill_hit)
                bullet_active[kill_slot] <= 1'b0;

            for (int i = 0; i < int'(N_SLOTS); i++) begin
                bullet_in_pixel[i] <= bullet_active[i]
                    && (hc >= x_q[i]) && ({1'b0, hc} < ({1'b0, x_q[i]} + SPAN))
                    && (vc >= y_q[i]) && ({1'b0, vc} < ({1'b0, y_q[i]} + SPAN));
                bullet_hc[10*i +: 10]   <= hc - x_q[i];
                bullet_vc[10*i +: 10]   <= vc - y_q[i];
                bullet_angle[4*i +: 4]  <= ang_q[i];
                bullet_type[4*i +: 4]   <= typ_q[i];
            end
        end
    end
endmodule

// File: tb/tb_bullet_manager.sv
// Self-checking bench for bullet_manager: directed scenarios plus a randomized
// run, all checked against a cycle-level behavioural model of the slot table.
module tb_bullet_manager;
    localparam int N = 20;
    localparam int BS = 36;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          frame_tick = 1'b0;
    logic [9:0]    hc = '0, vc = '0;
    logic          fire_req = 1'b0;
    logic [9:0]    fire_x = '0, fire_y = '0;
    logic [3:0]    fire_angle = '0, fire_type = '0;
    logic          fire_ack, fire_drop;
    logic          kill_valid = 1'b0;
    logic [4:0]    kill_slot = '0;
    logic [N-1:0]  bullet_active, bullet_in_pixel;
    logic [10*N-1:0] bullet_hc, bullet_vc;
    logic [4*N-1:0]  bullet_angle, bullet_type;
    logic          sweep_busy, frame_overrun;

    bullet_manager dut (
        .CLK(CLK), .RST(RST), .frame_tick(frame_tick), .hc(hc), .vc(vc),
        .fire_req(fire_req), .fire_x(fire_x), .fire_y(fire_y),
        .fire_angle(fire_angle), .fire_type(fire_type),
        .fire_ack(fire_ack), .fire_drop(fire_drop),
        .kill_valid(kill_valid), .kill_slot(kill_slot),
        .bullet_active(bullet_active), .bullet_in_pixel(bullet_in_pixel),
        .bullet_hc(bullet_hc), .bullet_vc(bullet_vc),
        .bullet_angle(bullet_angle), .bullet_type(bullet_type),
        .sweep_busy(sweep_busy), .frame_overrun(frame_overrun)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model of the slot table.
    int dx_tab[16] = '{4, 4, 3, 2, 0, -2, -3, -4, -4, -4, -3, -2, 0, 2, 3, 4};
    int m_x[N], m_y[N], m_ang[N], m_typ[N];
    bit m_act[N];
    int sweep_left = 0, sweep_pos = 0;
    bit m_ovr = 1'b0;
    bit e_pix[N];
    int e_hc[N], e_vc[N], e_ang[N], e_typ[N];

    function automatic int first_free();
        for (int i = 0; i < N; i++) if (!m_act[i]) return i;
        return -1;
    endfunction

    function automatic bit pred_ack();
        return !RST && sweep_left == 0 && !frame_tick && fire_req && first_free() >= 0;
    endfunction

    function automatic bit pred_drop();
        return !RST && sweep_left == 0 && !frame_tick && fire_req && first_free() < 0;
    endfunction

    // Advance one clock edge and apply the same edge to the model.
    task automatic tick();
        int f, nx, ny, k, h, v;
        bit kill;
        @(posedge CLK);
        h = int'(hc);
        v = int'(vc);
        f = first_free();
        kill = kill_valid && int'(kill_slot) < N;
        for (int i = 0; i < N; i++) begin
            e_pix[i] = !RST && m_act[i] && h >= m_x[i] && h < m_x[i] + BS && v >= m_y[i] && v < m_y[i] + BS;
            e_hc[i]  = RST ? 0 : ((h - m_x[i]) & 1023);
            e_vc[i]  = RST ? 0 : ((v - m_y[i]) & 1023);
            e_ang[i] = RST ? 0 : m_ang[i];
            e_typ[i] = RST ? 0 : m_typ[i];
        end
        if (RST) begin
            for (int i = 0; i < N; i++) begin
                m_x[i] = 0; m_y[i] = 0; m_ang[i] = 0; m_typ[i] = 0; m_act[i] = 0;
            end
            sweep_left = 0; sweep_pos = 0; m_ovr = 0;
        end else begin
            if (sweep_left > 0) begin
                if (frame_tick) m_ovr = 1;
                k = sweep_pos;
                if (m_act[k] && !(kill && int'(kill_slot) == k)) begin
                    nx = m_x[k] + dx_tab[m_ang[k]];
                    ny = m_y[k] + dx_tab[(m_ang[k] + 12) % 16];
                    if (nx < 0 || ny < 0 || nx + BS > 640 || ny + BS > 480) m_act[k] = 0;
                    else begin m_x[k] = nx; m_y[k] = ny; end
                end
                sweep_pos++;
                sweep_left--;
            end else if (frame_tick) begin
                sweep_left = N;
                sweep_pos = 0;
            end else if (fire_req && f >= 0) begin
                m_x[f] = int'(fire_x); m_y[f] = int'(fire_y);
                m_ang[f] = int'(fire_angle); m_typ[f] = int'(fire_type);
                m_act[f] = 1;
            end
            if (kill) m_act[kill_slot] = 0;
        end
        #1;
    endtask

    task automatic idle_inputs();
        frame_tick = 0; fire_req = 0; kill_valid = 0; kill_slot = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        RST = 1; tick(); tick(); RST = 0;
    endtask

    task automatic set_fire(input int x, input int y, input int a, input int t);
        fire_x = 10'(x); fire_y = 10'(y); fire_angle = 4'(a); fire_type = 4'(t); fire_req = 1;
    endtask

    task automatic test_reset();
        idle_inputs();
        RST = 1; fire_req = 1; #1;
        n_cmp++; if (fire_ack !== 1'b0) begin n_bad++; $display("FAIL reset_ack got=%b want=0", fire_ack); end
        tick(); tick(); RST = 0; fire_req = 0; #1;
        n_cmp++; if (bullet_active !== '0) begin n_bad++; $display("FAIL reset_active got=%h want=0", bullet_active); end
        n_cmp++; if (bullet_in_pixel !== '0) begin n_bad++; $display("FAIL reset_pix got=%h want=0", bullet_in_pixel); end
        n_cmp++; if (bullet_hc !== '0 || bullet_angle !== '0) begin n_bad++; $display("FAIL reset_fields got hc=%h ang=%h want=0", bullet_hc, bullet_angle); end
        n_cmp++; if (sweep_busy !== 1'b0 || frame_overrun !== 1'b0) begin n_bad++; $display("FAIL reset_flags got busy=%b ovr=%b want=0", sweep_busy, frame_overrun); end
    endtask

    task automatic test_spawn_pixel();
        hc = 10'd110; vc = 10'd60;
        set_fire(100, 50, 0, 1); #1;
        n_cmp++; if (fire_ack !== 1'b1) begin n_bad++; $display("FAIL spawn_ack got=%b want=1", fire_ack); end
        tick(); fire_req = 0;
        n_cmp++; if (bullet_active[0] !== 1'b1) begin n_bad++; $display("FAIL spawn_active got=%b want=1", bullet_active[0]); end
        tick();
        n_cmp++; if (bullet_in_pixel[0] !== 1'b1) begin n_bad++; $display("FAIL spawn_pix got=%b want=1", bullet_in_pixel[0]); end
        n_cmp++; if (bullet_hc[9:0] !== 10'd10 || bullet_vc[9:0] !== 10'd10) begin n_bad++; $display("FAIL spawn_hcvc got=%0d,%0d want=10,10", bullet_hc[9:0], bullet_vc[9:0]); end
        n_cmp++; if (bullet_type[3:0] !== 4'd1) begin n_bad++; $display("FAIL spawn_type got=%0d want=1", bullet_type[3:0]); end
    endtask

    task automatic test_full_drop();
        for (int s = 1; s < N; s++) begin
            set_fire($urandom_range(0, 600), $urandom_range(0, 440), $urandom_range(0, 15), $urandom_range(0, 2)); #1;
            n_cmp++; if (fire_ack !== 1'b1) begin n_bad++; $display("FAIL fill_ack slot=%0d got=%b want=1", s, fire_ack); end
            tick();
        end
        set_fire(10, 10, 3, 2); #1;
        n_cmp++; if (fire_drop !== 1'b1 || fire_ack !== 1'b0) begin n_bad++; $display("FAIL full_drop got drop=%b ack=%b want 1,0", fire_drop, fire_ack); end
        tick(); fire_req = 0;
        n_cmp++; if (bullet_active !== {N{1'b1}}) begin n_bad++; $display("FAIL full_table got=%h want=fffff", bullet_active); end
        kill_valid = 1; kill_slot = 5'd25; tick();
        n_cmp++; if (bullet_active !== {N{1'b1}}) begin n_bad++; $display("FAIL kill_oob got=%h want=fffff", bullet_active); end
        kill_slot = 5'd7; tick(); kill_valid = 0;
        n_cmp++; if (bullet_active[7] !== 1'b0) begin n_bad++; $display("FAIL kill7 got=%b want=0", bullet_active[7]); end
        set_fire(20, 30, 9, 2); #1;
        n_cmp++; if (fire_ack !== 1'b1) begin n_bad++; $display("FAIL refill_ack got=%b want=1", fire_ack); end
        tick(); fire_req = 0; tick();
        n_cmp++; if (bullet_active[7] !== 1'b1 || bullet_angle[28 +: 4] !== 4'd9 || bullet_type[28 +: 4] !== 4'd2)
            begin n_bad++; $display("FAIL refill7 got act=%b ang=%0d typ=%0d want 1,9,2", bullet_active[7], bullet_angle[28 +: 4], bullet_type[28 +: 4]); end
    endtask

    task automatic test_move_edge();
        int busy_cnt = 0;
        do_reset();
        set_fire(600, 200, 0, 2); tick(); fire_req = 0;
        frame_tick = 1; tick(); frame_tick = 0;
        for (int c = 0; c < 30; c++) begin
            if (sweep_busy) busy_cnt++;
            tick();
        end
        n_cmp++; if (busy_cnt != 20) begin n_bad++; $display("FAIL busy_len got=%0d want=20", busy_cnt); end
        hc = 10'd620; vc = 10'd210; tick();
        n_cmp++; if (bullet_in_pixel[0] !== 1'b1 || bullet_hc[9:0] !== 10'd16 || bullet_vc[9:0] !== 10'd10)
            begin n_bad++; $display("FAIL move_right got pix=%b hc=%0d vc=%0d want 1,16,10", bullet_in_pixel[0], bullet_hc[9:0], bullet_vc[9:0]); end
        frame_tick = 1; tick(); frame_tick = 0;
        repeat (22) tick();
        n_cmp++; if (bullet_active[0] !== 1'b0) begin n_bad++; $display("FAIL retire_right got=%b want=0", bullet_active[0]); end
    endtask

    task automatic test_diag();
        do_reset();
        set_fire(100, 100, 2, 0); tick();
        set_fire(300, 2, 12, 1); tick(); fire_req = 0;
        frame_tick = 1; tick(); frame_tick = 0;
        repeat (22) tick();
        hc = 10'd110; vc = 10'd110; tick();
        n_cmp++; if (bullet_in_pixel[0] !== 1'b1 || bullet_hc[9:0] !== 10'd7 || bullet_vc[9:0] !== 10'd7)
            begin n_bad++; $display("FAIL diag_move got pix=%b hc=%0d vc=%0d want 1,7,7", bullet_in_pixel[0], bullet_hc[9:0], bullet_vc[9:0]); end
        n_cmp++; if (bullet_active[1] !== 1'b0) begin n_bad++; $display("FAIL retire_up got=%b want=0", bullet_active[1]); end
    endtask

    task automatic test_collision();
        int waited = 0;
        do_reset();
        set_fire(200, 200, 4, 1); frame_tick = 1; #1;
        n_cmp++; if (fire_ack !== 1'b0) begin n_bad++; $display("FAIL tick_wins got ack=%b want=0", fire_ack); end
        tick(); frame_tick = 0;
        while (waited < 40) begin
            #1;
            if (fire_ack) break;
            tick();
            waited++;
        end
        n_cmp++; if (waited != 20 || sweep_busy !== 1'b0) begin n_bad++; $display("FAIL deferred_ack got wait=%0d busy=%b want 20,0", waited, sweep_busy); end
        tick(); fire_req = 0;
        frame_tick = 1; tick(); frame_tick = 0;
        repeat (5) tick();
        n_cmp++; if (frame_overrun !== 1'b0) begin n_bad++; $display("FAIL ovr_early got=%b want=0", frame_overrun); end
        frame_tick = 1; tick(); frame_tick = 0;
        n_cmp++; if (frame_overrun !== 1'b1) begin n_bad++; $display("FAIL ovr_set got=%b want=1", frame_overrun); end
        repeat (20) tick();
        n_cmp++; if (frame_overrun !== 1'b1) begin n_bad++; $display("FAIL ovr_sticky got=%b want=1", frame_overrun); end
    endtask

    task automatic test_kill_sweep();
        do_reset();
        for (int i = 0; i < 5; i++) begin set_fire(50 + 60 * i, 100, 0, 0); tick(); end
        fire_req = 0; hc = 10'd240; vc = 10'd100;
        frame_tick = 1; tick(); frame_tick = 0;
        repeat (3) tick();
        kill_valid = 1; kill_slot = 5'd3; tick(); kill_valid = 0;
        n_cmp++; if (bullet_active[3] !== 1'b0) begin n_bad++; $display("FAIL kill_sweep got=%b want=0", bullet_active[3]); end
        tick();
        n_cmp++; if (bullet_hc[30 +: 10] !== 10'd10 || bullet_hc[20 +: 10] !== 10'd66)
            begin n_bad++; $display("FAIL kill_nomove got hc3=%0d hc2=%0d want 10,66", bullet_hc[30 +: 10], bullet_hc[20 +: 10]); end
        do_reset();
        for (int i = 0; i < 3; i++) begin set_fire(80 * i, 50, 5, 2); tick(); end
        fire_req = 0;
        frame_tick = 1; tick(); frame_tick = 0;
        repeat (10) tick();
        RST = 1; fire_req = 1; #1;
        n_cmp++; if (fire_ack !== 1'b0 || fire_drop !== 1'b0) begin n_bad++; $display("FAIL rst_mid_ack got ack=%b drop=%b want 0,0", fire_ack, fire_drop); end
        tick(); RST = 0; fire_req = 0;
        n_cmp++; if (bullet_active !== '0 || sweep_busy !== 1'b0 || bullet_angle !== '0 || bullet_type !== '0)
            begin n_bad++; $display("FAIL rst_mid_out got act=%h busy=%b ang=%h want 0", bullet_active, sweep_busy, bullet_angle); end
        set_fire(10, 10, 0, 0); #1;
        n_cmp++; if (fire_ack !== 1'b1) begin n_bad++; $display("FAIL rst_mid_idle got ack=%b want=1", fire_ack); end
        tick(); fire_req = 0;
    endtask

    task automatic test_random();
        bit consumed;
        int j;
        logic [N-1:0] ea;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if (!fire_req && $urandom_range(0, 3) == 0)
                set_fire($urandom_range(0, 640), $urandom_range(0, 480), $urandom_range(0, 15), $urandom_range(0, 2));
            frame_tick = ($urandom_range(0, 59) == 0);
            kill_valid = ($urandom_range(0, 15) == 0);
            kill_slot  = 5'($urandom_range(0, 23));
            j = $urandom_range(0, N - 1);
            hc = 10'((m_x[j] + $urandom_range(0, 43) - 4) & 1023);
            vc = 10'((m_y[j] + $urandom_range(0, 43) - 4) & 1023);
            #1;
            n_cmp++; if (fire_ack !== pred_ack() || fire_drop !== pred_drop())
                begin n_bad++; $display("FAIL rnd_hs c=%0d got ack=%b drop=%b want %b,%b", c, fire_ack, fire_drop, pred_ack(), pred_drop()); end
            consumed = pred_ack() || pred_drop();
            tick();
            if (consumed) fire_req = 0;
            for (int i = 0; i < N; i++) ea[i] = m_act[i];
            n_cmp++; if (bullet_active !== ea) begin n_bad++; $display("FAIL rnd_active c=%0d got=%h want=%h", c, bullet_active, ea); end
            n_cmp++; if (sweep_busy !== (sweep_left > 0) || frame_overrun !== m_ovr)
                begin n_bad++; $display("FAIL rnd_flags c=%0d got busy=%b ovr=%b want %b,%b", c, sweep_busy, frame_overrun, sweep_left > 0, m_ovr); end
            for (int i = 0; i < N; i++) begin
                n_cmp++;
                if (bullet_in_pixel[i] !== e_pix[i] || bullet_angle[4*i +: 4] !== 4'(e_ang[i]) || bullet_type[4*i +: 4] !== 4'(e_typ[i])
                    || (e_pix[i] && (bullet_hc[10*i +: 10] !== 10'(e_hc[i]) || bullet_vc[10*i +: 10] !== 10'(e_vc[i])))) begin
                    n_bad++;
                    $display("FAIL rnd_slot c=%0d s=%0d got pix=%b hc=%0d vc=%0d ang=%0d typ=%0d want %b,%0d,%0d,%0d,%0d", c, i,
                             bullet_in_pixel[i], bullet_hc[10*i +: 10], bullet_vc[10*i +: 10], bullet_angle[4*i +: 4], bullet_type[4*i +: 4],
                             e_pix[i], e_hc[i], e_vc[i], e_ang[i], e_typ[i]);
                end
            end
        end
        idle_inputs();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_spawn_pixel();
        test_full_drop();
        test_move_edge();
        test_diag();
        test_collision();
        test_kill_sweep();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/bullet_manager.md
Name: bullet_manager

Overview:
- Owns the bullet slot table that feeds the bullet sprite renderer.
- Accepts spawn requests through a req/ack handshake and moves every active bullet once per frame with a sequential sweep.
- Retires a bullet when it leaves the visible area or when a kill request names its slot.
- For every pixel, outputs per-slot active, in-pixel, sprite-relative hc/vc, angle and type, registered, ready for the renderer's lookup.

Parameters:
- N_SLOTS, 20, number of bullet slots; slot i occupies bit/field i of every per-slot bus.
- B_SIZE, 36, sprite edge in pixels (square).
- H_ACTIVE, 640, visible width in pixels.
- V_ACTIVE, 480, visible height in pixels.

Ports:
- CLK  in  1  system clock.
- RST  in  1  synchronous, active-high reset.
- frame_tick  in  1  one-cycle pulse at start of vertical blanking.
- hc  in  10  current pixel column.
- vc  in  10  current pixel row.
- fire_req  in  1  spawn request; held high until fire_ack.
- fire_x  in  10  spawn top-left x.
- fire_y  in  10  spawn top-left y.
- fire_angle  in  4  direction index 0..15.
- fire_type  in  4  sprite type 0..2.
- fire_ack  out  1  one-cycle accept pulse.
- fire_drop  out  1  one-cycle pulse when the request is consumed with no free slot.
- kill_valid  in  1  retire request.
- kill_slot  in  5  slot to retire.
- bullet_active  out  N_SLOTS  per-slot active flag.
- bullet_in_pixel  out  N_SLOTS  (hc,vc) lies inside slot sprite.
- bullet_hc  out  10*N_SLOTS  hc - x for each slot.
- bullet_vc  out  10*N_SLOTS  vc - y for each slot.
- bullet_angle  out  4*N_SLOTS  stored angle.
- bullet_type  out  4*N_SLOTS  stored type.
- sweep_busy  out  1  high during the move sweep.
- frame_overrun  out  1  sticky; set when frame_tick arrives while the sweep is busy; cleared by RST.

Behaviour:
- Reset: all slots inactive, x/y/angle/type = 0, FSM = IDLE, all outputs 0.
- Slot state: x, y (10-bit unsigned), angle, type, active.
- FSM states:
  - IDLE: frame_tick -> SWEEP with idx = 0. Otherwise, if fire_req is high, service the spawn.
  - SWEEP: processes slot idx each cycle; idx increments by 1; after idx = N_SLOTS-1 -> IDLE. Takes exactly N_SLOTS cycles; sweep_busy is high throughout.
- Spawn (IDLE only, one cycle):
  - Lowest-index inactive slot is loaded with the fire_* fields and set active.
  - fire_ack pulses in the same cycle; the slot shows active on the next cycle.
  - No free slot: fire_drop pulses instead, the table is unchanged, and the request counts as consumed.
  - fire_req is not serviced during SWEEP; the requester holds it.
  - frame_tick and fire_req in the same IDLE cycle: frame_tick wins and the spawn waits until the sweep ends.
- Velocity table, fixed, indexed by angle 0..15:
  - dx = 4,4,3,2,0,-2,-3,-4,-4,-4,-3,-2,0,2,3,4
  - dy[k] = dx[(k+12) mod 16]
  - Angle 0 = right, 4 = down, 8 = left, 12 = up.
- Move (active slot during SWEEP):
  - nx = x + dx and ny = y + dy, computed in 12-bit signed.
  - If nx < 0, ny < 0, nx + B_SIZE > H_ACTIVE or ny + B_SIZE > V_ACTIVE: clear active and leave x/y unchanged.
  - Otherwise write nx/ny. Inactive slots are skipped and unchanged.
- Kill:
  - kill_valid with kill_slot < N_SLOTS clears that slot's active at the next edge, in any state.
  - It has priority over a move or spawn targeting the same slot in the same cycle. The slot counts as free for spawns starting the following cycle.
  - kill_slot >= N_SLOTS is ignored.
- Pixel outputs, registered, latency 1 from hc/vc:
  - bullet_in_pixel[i] = active & (x <= hc < x + B_SIZE) & (y <= vc < y + B_SIZE).
  - bullet_hc[i] = (hc - x) mod 1024 and bullet_vc[i] = (vc - y) mod 1024. They are valid only when in_pixel = 1, which keeps them in 0..35.
  - bullet_angle/type track the slot registers with the same 1-cycle latency.
  - Table updates become visible on the pixel outputs one cycle after the write.
- Reset mid-sweep: returns to IDLE with all slots cleared; no ack or drop is emitted.

Test Plan:
1. Reset then fire_req (x=100, y=50, angle=0, type=1) -> fire_ack in the same cycle; slot 0 active next cycle. With hc=110, vc=60: 1 cycle later in_pixel[0]=1, bullet_hc[0]=10, bullet_vc[0]=10, type[0]=1.
2. 20 spawns then a 21st fire_req -> fire_drop pulse, no ack, table unchanged. Kill slot 7, then fire_req -> ack, new bullet in slot 7.
3. Bullet at x=600, y=200, angle 0; one frame_tick per frame -> x = 604 after the 1st frame, retired on the 2nd (608+36 > 640). sweep_busy is high for exactly 20 cycles per frame.
4. Bullet at (100,100), angle 2 -> after 1 frame at (103,103); angle 12 from y=2 -> retired on the 1st sweep.
5. fire_req and frame_tick asserted in the same IDLE cycle -> no ack until sweep_busy drops; ack in the first IDLE cycle after. A frame_tick arriving mid-sweep sets frame_overrun.
6. kill_valid for slot 3 in the same cycle the sweep moves slot 3 -> slot 3 inactive and x/y unchanged. Assert RST at sweep idx=10 -> all outputs 0 next cycle, FSM in IDLE.
